// File: rtl/credit_count_receiver_pkg.sv
// ---------------------------------------------------------------------------
// credit_count_receiver_pkg
//   Shared definitions for the credit-count receiver slice.
//   - rxState_e             : receiver control states (SETTLE, RUN, ERROR)
//   - DEFAULT_WIDTH         : default width of remote/local/available counts
//   - DEFAULT_SETTLE_CYCLES : default cycles to wait before trusting the
//                             remote count after reset release
// ---------------------------------------------------------------------------
package credit_count_receiver_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    RUN    = 2'd1,
    ERROR  = 2'd2
  } rxState_e;

  localparam int DEFAULT_WIDTH         = 5;
  localparam int DEFAULT_SETTLE_CYCLES = 3;

endpackage

// File: rtl/credit_settle_counter.sv
// ---------------------------------------------------------------------------
// credit_settle_counter
//   Down-counter loaded with SETTLE_CYCLES on reset. While enabled it counts
//   down once per cycle; done is raised in the cycle whose rising edge takes
//   the count to zero, so the owner can leave its settle state on that edge.
//
//   Ports
//     clk     : clock, rising edge
//     aresetn : asynchronous active-low reset (reloads SETTLE_CYCLES)
//     enable  : count down this cycle
//     done    : settle period ends at the coming rising edge
// ---------------------------------------------------------------------------
module credit_settle_counter
  import credit_count_receiver_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic clk,
  input  logic aresetn,
  input  logic enable,
  output logic done
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(SETTLE_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  // A count of 1 reaches zero on this edge; a count already at zero (only
  // possible with SETTLE_CYCLES == 0) means the wait is over immediately.
  assign done = enable && (count <= CW'(1));

endmodule

// File: rtl/credit_count_receiver.sv
// ---------------------------------------------------------------------------
// credit_count_receiver
//   Receives a free-running wrapping credit count from a producer domain and
//   turns it into a registered number of locally available credits.
//   available = remoteCount - localCount (mod 2^WIDTH), where localCount
//   advances on every accepted consume.
//
//   Optional feature: define CREDIT_RX_ERROR_CHECK_EN to build protocol
//   checking (backward/too-large remote steps, consume with no credit). When
//   undefined the ERROR state is never entered and error is tied low.
//
//   Parameters
//     WIDTH         : width of remote, local and available counts
//     SETTLE_CYCLES : cycles after reset release before remoteCount is used
//
//   Ports
//     clk            : clock, rising edge
//     aresetn        : asynchronous active-low reset
//     remoteCount    : synchronised producer count (wraps)
//     consume        : take one credit this cycle
//     available      : registered credit count
//     availableValid : available is meaningful, consume may be accepted
//     error          : sticky protocol violation flag
// ---------------------------------------------------------------------------
module credit_count_receiver
  import credit_count_receiver_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] remoteCount,
  input  logic             consume,
  output logic [WIDTH-1:0] available,
  output logic             availableValid,
  output logic             error
);

  rxState_e         state;
  logic [WIDTH-1:0] localCount;
  logic [WIDTH-1:0] remoteReg;
  logic [WIDTH-1:0] localNext;
  logic             settleEn;
  logic             settleDone;
  logic             accepted;

  // Modular difference of two wrapping counts.
  function automatic logic [WIDTH-1:0] creditDiff(input logic [WIDTH-1:0] produced,
                                                  input logic [WIDTH-1:0] taken);
    return produced - taken;
  endfunction

  assign settleEn = (state == SETTLE);

  credit_settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) uSettle (
    .clk    (clk),
    .aresetn(aresetn),
    .enable (settleEn),
    .done   (settleDone)
  );

  // Only a nonzero, valid credit count in RUN can be spent, so the same
  // credit can never be taken twice.
  assign accepted  = (state == RUN) && availableValid && (available != '0) && consume;
  assign localNext = localCount + WIDTH'(accepted);

`ifdef CREDIT_RX_ERROR_CHECK_EN
  logic [WIDTH-1:0] remoteStep;
  logic             countBackward;
  logic             overdraw;
  logic             violation;
  logic             errorFlag;

  // A step with the MSB set is either a backward move or a jump of half the
  // count range or more; neither can be told apart from corruption.
  assign remoteStep    = creditDiff(remoteCount, remoteReg);
  assign countBackward = remoteStep[WIDTH-1];
  assign overdraw      = consume && (available == '0);
  assign violation     = countBackward || overdraw;
  assign error         = errorFlag;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= SETTLE;
      localCount     <= '0;
      remoteReg      <= '0;
      available      <= '0;
      availableValid <= 1'b0;
`ifdef CREDIT_RX_ERROR_CHECK_EN
      errorFlag      <= 1'b0;
`endif
    end else begin
      remoteReg <= remoteCount;
      case (state)
        SETTLE: begin
          available      <= '0;
          availableValid <= 1'b0;
          // Align local with the last sampled remote so credits start at 0.
          if (settleDone) begin
            state          <= RUN;
            localCount     <= remoteReg;
            availableValid <= 1'b1;
          end
        end
        RUN: begin
`ifdef CREDIT_RX_ERROR_CHECK_EN
          if (violation) begin
            state          <= ERROR;
            available      <= '0;
            availableValid <= 1'b0;
            errorFlag      <= 1'b1;
          end else
`endif
          begin
            localCount     <= localNext;
            available      <= creditDiff(remoteCount, localNext);
            availableValid <= 1'b1;
          end
        end
`ifdef CREDIT_RX_ERROR_CHECK_EN
        // Left only through reset.
        ERROR: begin
          available      <= '0;
          availableValid <= 1'b0;
          errorFlag      <= 1'b1;
        end
`endif
        default: begin
          state          <= SETTLE;
          available      <= '0;
          availableValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_credit_count_receiver.sv
// ---------------------------------------------------------------------------
// tb_credit_count_receiver
//   Self-checking bench for credit_count_receiver. Reference model tracks
//   credits as (remote count at start of RUN, number of credits taken) and
//   derives the expected available count with modular arithmetic.
// ---------------------------------------------------------------------------
module tb_credit_count_receiver;

  localparam int W  = 5;
  localparam int SC = 3;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [W-1:0] remoteCount;
  logic         consume;
  logic [W-1:0] available;
  logic         availableValid;
  logic         error;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = settling, 1 = running, 2 = error
  int           mPhase;
  int           settleLeft;
  logic [W-1:0] mAvail;
  logic         mValid;
  logic         mErr;
  logic [W-1:0] prevRemote;
  logic [W-1:0] base;
  int           taken;

  credit_count_receiver #(
    .WIDTH        (W),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .remoteCount   (remoteCount),
    .consume       (consume),
    .available     (available),
    .availableValid(availableValid),
    .error         (error)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mPhase     = 0;
    settleLeft = SC;
    mAvail     = '0;
    mValid     = 1'b0;
    mErr       = 1'b0;
    prevRemote = '0;
    base       = '0;
    taken      = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic cycle(input logic [W-1:0] r, input logic c);
`ifdef CREDIT_RX_ERROR_CHECK_EN
    logic [W-1:0] step;
    step = r - prevRemote;
`endif
    remoteCount = r;
    consume     = c;
    if (mPhase == 0) begin
      settleLeft--;
      if (settleLeft <= 0) begin
        mPhase = 1;
        base   = prevRemote;
        taken  = 0;
        mValid = 1'b1;
        mAvail = '0;
      end
    end else if (mPhase == 1) begin
`ifdef CREDIT_RX_ERROR_CHECK_EN
      if ((int'(step) >= 2 ** (W - 1)) || (c && (mAvail == '0))) begin
        mPhase = 2;
        mValid = 1'b0;
        mAvail = '0;
        mErr   = 1'b1;
      end else
`endif
      begin
        if (c && (mAvail != '0)) taken++;
        mAvail = W'(int'(r) - int'(base) - taken);
      end
    end
    prevRemote = r;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [W-1:0] r);
    aresetn     = 1'b0;
    remoteCount = r;
    consume     = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (SC) cycle(r, 1'b0);
  endtask

  task automatic test_reset();
    aresetn     = 1'b0;
    remoteCount = '0;
    consume     = 1'b0;
    modelReset();
    #1;
    checks++;
    if ({available, availableValid, error} !== {W'(0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_assert: got avail=%0d vld=%0b err=%0b, want 0/0/0",
               available, availableValid, error);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({available, availableValid, error} !== {W'(0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got avail=%0d vld=%0b err=%0b, want 0/0/0",
               available, availableValid, error);
    end
    aresetn = 1'b1;
    for (int i = 0; i <= SC; i++) begin
      checks++;
      if ({availableValid, available} !== {(i == SC), W'(0)}) begin
        errors++;
        $display("FAIL settle_cycle%0d: got vld=%0b avail=%0d, want vld=%0b avail=0",
                 i, availableValid, available, (i == SC));
      end
      if (i < SC) cycle('0, 1'b0);
    end
  endtask

  task automatic test_step_consume();
    doReset('0);
    cycle(W'(4), 1'b0);
    checks++;
    if ({availableValid, available} !== {1'b1, W'(4)}) begin
      errors++;
      $display("FAIL step_0_to_4: got vld=%0b avail=%0d, want vld=1 avail=4",
               availableValid, available);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(W'(4), 1'b1);
      checks++;
      if (available !== W'(3 - i)) begin
        errors++;
        $display("FAIL consume_%0d: got avail=%0d, want %0d", i + 1, available, 3 - i);
      end
    end
`ifndef CREDIT_RX_ERROR_CHECK_EN
    cycle(W'(4), 1'b1);
    cycle(W'(4), 1'b0);
    checks++;
    if ({available, error} !== {W'(0), 1'b0}) begin
      errors++;
      $display("FAIL fifth_consume: got avail=%0d err=%0b, want avail=0 err=0",
               available, error);
    end
    cycle(W'(5), 1'b0);
    checks++;
    if (available !== W'(1)) begin
      errors++;
      $display("FAIL after_fifth: got avail=%0d, want 1", available);
    end
`endif
  endtask

  task automatic test_wraparound();
    doReset('0);
    cycle(W'(14), 1'b0);
    cycle(W'(28), 1'b0);
    cycle(W'(29), 1'b0);
    checks++;
    if (available !== W'(29)) begin
      errors++;
      $display("FAIL wrap_fill: got avail=%0d, want 29", available);
    end
    repeat (29) cycle(W'(29), 1'b1);
    checks++;
    if (available !== W'(0)) begin
      errors++;
      $display("FAIL wrap_drain: got avail=%0d, want 0", available);
    end
    cycle(W'(30), 1'b0);
    cycle(W'(2), 1'b0);
    checks++;
    if (available !== W'(5)) begin
      errors++;
      $display("FAIL wrap_30_to_2: got avail=%0d, want 5", available);
    end
  endtask

  // Continues from test_wraparound: remote=2, available=5.
  task automatic test_same_cycle();
    cycle(W'(2), 1'b1);
    cycle(W'(2), 1'b1);
    checks++;
    if (available !== W'(3)) begin
      errors++;
      $display("FAIL same_cycle_setup: got avail=%0d, want 3", available);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(W'(3 + i), 1'b1);
      checks++;
      if (available !== W'(3)) begin
        errors++;
        $display("FAIL same_cycle_%0d: got avail=%0d, want 3", i, available);
      end
    end
  endtask

  task automatic test_mid_reset();
    doReset('0);
    cycle(W'(7), 1'b0);
    #3;
    aresetn = 1'b0;
    modelReset();
    #1;
    checks++;
    if ({available, availableValid, error} !== {W'(0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_async: got avail=%0d vld=%0b err=%0b, want 0/0/0",
               available, availableValid, error);
    end
    doReset(W'(17));
    checks++;
    if ({availableValid, available} !== {1'b1, W'(0)}) begin
      errors++;
      $display("FAIL no_history: got vld=%0b avail=%0d, want vld=1 avail=0",
               availableValid, available);
    end
    cycle(W'(19), 1'b0);
    checks++;
    if (available !== W'(2)) begin
      errors++;
      $display("FAIL post_reset_step: got avail=%0d, want 2", available);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r;
    logic         c;
    r = W'($urandom);
    doReset(r);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = r + W'($urandom_range(1, 3));
      c = 1'($urandom_range(0, 1));
`ifdef CREDIT_RX_ERROR_CHECK_EN
      if (mAvail == '0) c = 1'b0;
`endif
      cycle(r, c);
      checks++;
      if ({available, availableValid, error} !== {mAvail, mValid, mErr}) begin
        errors++;
        $display("FAIL random_cyc%0d: got avail=%0d vld=%0b err=%0b, want avail=%0d vld=%0b err=%0b",
                 i, available, availableValid, error, mAvail, mValid, mErr);
      end
    end
  endtask

`ifdef CREDIT_RX_ERROR_CHECK_EN
  task automatic test_error_check();
    doReset('0);
    cycle(W'(10), 1'b0);
    cycle(W'(8), 1'b0);
    checks++;
    if ({error, availableValid, available} !== {1'b1, 1'b0, W'(0)}) begin
      errors++;
      $display("FAIL backward_step: got err=%0b vld=%0b avail=%0d, want 1/0/0",
               error, availableValid, available);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(W'(12 + i), 1'b1);
      checks++;
      if ({error, availableValid, available} !== {1'b1, 1'b0, W'(0)}) begin
        errors++;
        $display("FAIL error_sticky_%0d: got err=%0b vld=%0b avail=%0d, want 1/0/0",
                 i, error, availableValid, available);
      end
    end
    doReset('0);
    checks++;
    if ({error, availableValid} !== 2'b01) begin
      errors++;
      $display("FAIL error_cleared: got err=%0b vld=%0b, want 0/1", error, availableValid);
    end
    cycle('0, 1'b1);
    checks++;
    if ({error, availableValid} !== 2'b10) begin
      errors++;
      $display("FAIL overdraw: got err=%0b vld=%0b, want 1/0", error, availableValid);
    end
  endtask
`else
  task automatic test_no_error_check();
    doReset('0);
    for (int i = 0; i < 3; i++) begin
      cycle('0, 1'b1);
      checks++;
      if ({error, available, availableValid} !== {1'b0, W'(0), 1'b1}) begin
        errors++;
        $display("FAIL overdraw_ignored_%0d: got err=%0b avail=%0d vld=%0b, want 0/0/1",
                 i, error, available, availableValid);
      end
    end
    cycle(W'(10), 1'b0);
    cycle(W'(8), 1'b0);
    checks++;
    if ({error, available} !== {1'b0, mAvail}) begin
      errors++;
      $display("FAIL backward_ignored: got err=%0b avail=%0d, want err=0 avail=%0d",
               error, available, mAvail);
    end
  endtask
`endif

  initial begin
    aresetn     = 1'b0;
    remoteCount = '0;
    consume     = 1'b0;
    modelReset();
    test_reset();
    test_step_consume();
    test_wraparound();
    test_same_cycle();
    test_mid_reset();
    test_random();
`ifdef CREDIT_RX_ERROR_CHECK_EN
    test_error_check();
`else
    test_no_error_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/credit_count_receiver.md
CREDIT_COUNT_RECEIVER -- requirements
Module: credit_count_receiver

Interface
REQ-001 Parameter WIDTH, default 5: bit width of the remote count, local count and available count.
REQ-002 Parameter SETTLE_CYCLES, default 3: number of cycles after reset release before the block trusts remoteCount.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port aresetn, input, 1: reset, asynchronous assert and active-low.
REQ-005 Port remoteCount, input, WIDTH: free-running, wrapping binary count from the producer domain, already decoded and synchronised to clk.
REQ-006 Port consume, input, 1: request to take one credit this cycle.
REQ-007 Port available, output, WIDTH: credits available, registered.
REQ-008 Port availableValid, output, 1: high when available is meaningful and consume can be accepted.
REQ-009 Port error, output, 1: sticky protocol-violation flag.

Function
REQ-010 States SETTLE, RUN and ERROR; SETTLE is entered on reset.
REQ-011 SETTLE: a down-counter loaded with SETTLE_CYCLES decrements each cycle; when it reaches 0, go to RUN.
REQ-012 On the SETTLE-to-RUN edge, localCount takes the value of remoteReg, so available starts at 0.
REQ-013 remoteReg samples remoteCount every cycle in every state.
REQ-014 A consume is accepted only when state is RUN, availableValid=1 and available!=0.
REQ-015 In RUN, localCount increments by 1 mod 2^WIDTH on each accepted consume.
REQ-016 In RUN, available is registered as (remoteCount - (localCount + accepted)) mod 2^WIDTH.
REQ-017 remoteCount-to-available latency is 1 cycle.
REQ-018 An accepted consume is reflected in available on the next cycle; the same credit is never consumed twice.
REQ-019 A remoteCount increment and an accepted consume in the same cycle leave available unchanged.
REQ-020 Wrap-around is handled by modular subtraction; no special casing.
REQ-021 availableValid is 1 only in RUN.
REQ-022 In SETTLE and ERROR, available is held at 0 and consume is ignored.

Reset
REQ-023 While aresetn=0: state=SETTLE, settle counter=SETTLE_CYCLES, localCount=0, remoteReg=0, available=0, availableValid=0, error=0.
REQ-024 Reset asserted mid-operation, including in ERROR, immediately forces the REQ-023 values.
REQ-025 No credit history survives reset.

Configuration
REQ-026 Macro CREDIT_RX_ERROR_CHECK_EN compiles in error checking.
REQ-027 With the macro, in RUN, (remoteCount - remoteReg) having its MSB set (the count moved backward or jumped by 2^(WIDTH-1) or more) moves the block to ERROR and sets error=1.
REQ-028 With the macro, in RUN, consume=1 while available==0 moves the block to ERROR and sets error=1.
REQ-029 With the macro, ERROR is exited only by reset.
REQ-030 Without the macro, the ERROR state is not built and error is tied to 0; the port remains present.

Structure
REQ-031 A shared package holds the state enum (SETTLE, RUN, ERROR) and the default WIDTH and SETTLE_CYCLES constants.
REQ-032 One sub-module, credit_settle_counter, holds the SETTLE down-counter and asserts a done signal.

Verification
REQ-033 Release reset with remoteCount=0 -> availableValid=0 for 3 cycles, then availableValid=1 and available=0.
REQ-034 Step remoteCount 0 to 4 in RUN -> available=4 one cycle later; 4 consecutive consumes -> available 3, 2, 1, 0; a 5th consume is not accepted.
REQ-035 Wrap-around: localCount=29 and remoteCount goes 30 to 2 -> available=5.
REQ-036 Same cycle remoteCount+1 and consume, with available=3 -> available stays 3.
REQ-037 With the macro, remoteReg=10 and remoteCount=8 -> error=1, availableValid=0 next cycle, and the state is held until aresetn pulses low.
REQ-038 Without the macro, consume while available=0 -> error stays 0 and available stays 0.
